// File: rtl/thmn_weighted_bank.sv
// Bank of weighted NCL threshold gates with hysteresis, plus a per-channel monotonicity monitor and a DATA/NULL wavefront counter.
// Latency: one cycle from sampled x to y. No backpressure: en=0 freezes all state.
module thmn_weighted_bank #(
  parameter int              CH      = 1,
  parameter int              N       = 4,
  parameter int              W       = 4,
  parameter logic [N*W-1:0]  WEIGHTS = 16'h1122,
  parameter int              THRESH  = 4,
  parameter int              CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [CH*N-1:0]   x,
  input  logic              vio_clr,
  output logic [CH-1:0]     y,
  output logic [CH-1:0]     vio,
  output logic              phase,
  output logic [CNT_W-1:0]  wave_cnt
);

  localparam int SUMW = $clog2(N * (2**W - 1) + 1);
  localparam logic [SUMW-1:0] THRESH_S = SUMW'(THRESH);

  typedef enum logic {
    S_NULL = 1'b0,
    S_DATA = 1'b1
  } state_t;

  logic [CH*N-1:0] x_q;
  logic [CH-1:0]   y_q;
  logic [CH-1:0]   vio_q;

  // Previous input sample feeds the monotonicity monitor.
  always_ff @(posedge clk) begin
    if (rst) begin
      x_q <= '0;
    end else if (en) begin
      x_q <= x;
    end
  end

  for (genvar k = 0; k < CH; k++) begin : g_ch
    logic [N-1:0]    xc;
    logic [N-1:0]    xqc;
    logic [SUMW-1:0] sum;
    logic            set_c;
    logic            clr_c;
    logic            viol;
    logic            y_r;
    logic            vio_r;

    assign xc  = x[k*N +: N];
    assign xqc = x_q[k*N +: N];

    always_comb begin
      sum = '0;
      for (int i = 0; i < N; i++) begin
        if (xc[i]) begin
          sum = sum + SUMW'(WEIGHTS[i*W +: W]);
        end
      end
    end

    // Zero-weight inputs still hold the gate set until every input returns to NULL.
    assign set_c = !y_r && (sum >= THRESH_S);
    assign clr_c = y_r && (xc == '0);
    assign viol  = y_r ? |(xc & ~xqc) : |(xqc & ~xc);

    always_ff @(posedge clk) begin
      if (rst) begin
        y_r   <= 1'b0;
        vio_r <= 1'b0;
      end else if (en) begin
        if (set_c) begin
          y_r <= 1'b1;
        end else if (clr_c) begin
          y_r <= 1'b0;
        end
        if (viol) begin
          vio_r <= 1'b1;
        end else if (vio_clr) begin
          vio_r <= 1'b0;
        end
      end
    end

    assign y_q[k]   = y_r;
    assign vio_q[k] = vio_r;
  end

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_NULL;
      cnt   <= '0;
    end else if (en) begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // A wavefront completes when the whole bank has returned to NULL after DATA.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      S_NULL: begin
        if (&y_q) begin
          state_nxt = S_DATA;
        end
      end
      S_DATA: begin
        if (~|y_q) begin
          state_nxt = S_NULL;
          cnt_nxt   = cnt + CNT_W'(1);
        end
      end
      default: state_nxt = S_NULL;
    endcase
  end

  assign y        = y_q;
  assign vio      = vio_q;
  assign phase    = (state == S_DATA);
  assign wave_cnt = cnt;

endmodule
